// File: rtl/cbd_down_counter.sv
// WIDTH-bit synchronous down counter with borrow-in/borrow-out cascade, parallel load
// and asynchronous active-low clear. Optional auto-reload on terminal count: CBD_AUTORELOAD_EN.
module cbd_down_counter #(
  parameter int unsigned WIDTH = 2,
  parameter int unsigned INIT  = 0
) (
  input  logic             clk_i,
  input  logic             cd_i,
  input  logic             ld_i,
  input  logic [WIDTH-1:0] d_i,
  input  logic             bi_i,
  output logic [WIDTH-1:0] q_o,
  output logic             bo_o,
  output logic             zero_o
);

  localparam logic [WIDTH-1:0] INIT_W = WIDTH'(INIT);
  localparam logic [WIDTH-1:0] ONE_W  = WIDTH'(1);
  localparam logic [WIDTH-1:0] ZERO_W = '0;

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic             q_is_zero;

  assign q_is_zero = (q_q == ZERO_W);

`ifdef CBD_AUTORELOAD_EN
  logic [WIDTH-1:0] rld_q;
  logic [WIDTH-1:0] rld_d;

  // Reload value: all-ones after clear so an unloaded counter behaves like plain wrap.
  always_comb begin
    rld_d = rld_q;
    if (ld_i) begin
      rld_d = d_i;
    end
  end

  always_ff @(posedge clk_i or negedge cd_i) begin
    if (!cd_i) begin
      rld_q <= '1;
    end else begin
      rld_q <= rld_d;
    end
  end
`endif

  // Next count: load beats decrement beats hold.
  always_comb begin
    q_d = q_q;
    if (ld_i) begin
      q_d = d_i;
    end else if (bi_i) begin
`ifdef CBD_AUTORELOAD_EN
      if (q_is_zero) begin
        q_d = rld_q;
      end else begin
        q_d = q_q - ONE_W;
      end
`else
      q_d = q_q - ONE_W;
`endif
    end
  end

  always_ff @(posedge clk_i or negedge cd_i) begin
    if (!cd_i) begin
      q_q <= INIT_W;
    end else begin
      q_q <= q_d;
    end
  end

  // Borrow ripples combinationally through a cascade; masked during load.
  assign q_o    = q_q;
  assign zero_o = q_is_zero;
  assign bo_o   = bi_i && q_is_zero && !ld_i;

endmodule

// File: tb/tb_cbd_down_counter.sv
// Directed self-checking bench for cbd_down_counter: single stage, two-stage cascade,
// and a WIDTH=3/INIT=2 instance. Expectations follow CBD_AUTORELOAD_EN when defined.
module tb_cbd_down_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int vecs  = 0;
  int fails = 0;

  // Stage A: WIDTH=2, INIT=0
  logic       cd_a, ld_a, bi_a, bo_a, zero_a;
  logic [1:0] d_a, q_a;
  // Cascade: two WIDTH=2 stages, BO0 -> BI1
  logic       cd_c, ld_c, bi_c, bo0, bo1, zero0, zero1;
  logic [1:0] d0, d1, q0, q1;
  // Stage K: WIDTH=3, INIT=2
  logic       cd_k, ld_k, bi_k, bo_k, zero_k;
  logic [2:0] d_k, q_k;

  cbd_down_counter #(.WIDTH(2), .INIT(0)) u_a (
    .clk_i(clk), .cd_i(cd_a), .ld_i(ld_a), .d_i(d_a), .bi_i(bi_a),
    .q_o(q_a), .bo_o(bo_a), .zero_o(zero_a));

  cbd_down_counter #(.WIDTH(2), .INIT(0)) u_s0 (
    .clk_i(clk), .cd_i(cd_c), .ld_i(ld_c), .d_i(d0), .bi_i(bi_c),
    .q_o(q0), .bo_o(bo0), .zero_o(zero0));

  cbd_down_counter #(.WIDTH(2), .INIT(0)) u_s1 (
    .clk_i(clk), .cd_i(cd_c), .ld_i(ld_c), .d_i(d1), .bi_i(bo0),
    .q_o(q1), .bo_o(bo1), .zero_o(zero1));

  cbd_down_counter #(.WIDTH(3), .INIT(2)) u_k (
    .clk_i(clk), .cd_i(cd_k), .ld_i(ld_k), .d_i(d_k), .bi_i(bi_k),
    .q_o(q_k), .bo_o(bo_k), .zero_o(zero_k));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] exp_c;
  logic [1:0] exp_a;

  initial begin
    cd_a = 1'b1; ld_a = 1'b0; bi_a = 1'b0; d_a = 2'd0;
    cd_c = 1'b0; ld_c = 1'b0; bi_c = 1'b0; d0 = 2'd0; d1 = 2'd0;
    cd_k = 1'b0; ld_k = 1'b0; bi_k = 1'b0; d_k = 3'd0;
    tick();
    tick();
    cd_c = 1'b1;

    // Asynchronous clear in mid-cycle, no clock edge needed
    #3 cd_a = 1'b0;
    #1;
    check("a_clr_q", 32'(q_a), 32'd0);
    check("a_clr_zero", 32'(zero_a), 32'd1);
    check("a_clr_bo_bi0", 32'(bo_a), 32'd0);
    bi_a = 1'b1;
    #1;
    check("a_clr_bo_bi1", 32'(bo_a), 32'd1);
    tick();
    check("a_clr_held", 32'(q_a), 32'd0);
    cd_a = 1'b1;

    // Count down 3,2,1,0 with borrow only at zero
    exp_a = 2'd3;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("a_cnt_q", 32'(q_a), 32'(exp_a));
      check("a_cnt_bo", 32'(bo_a), (exp_a == 2'd0) ? 32'd1 : 32'd0);
      check("a_cnt_zero", 32'(zero_a), (exp_a == 2'd0) ? 32'd1 : 32'd0);
      exp_a = exp_a - 2'd1;
    end

    // Load beats decrement; borrow masked during load
    ld_a = 1'b1; d_a = 2'd2;
    #1;
    check("a_ld_bo_masked", 32'(bo_a), 32'd0);
    check("a_ld_zero", 32'(zero_a), 32'd1);
    tick();
    check("a_ld_q", 32'(q_a), 32'd2);
    ld_a = 1'b0;
    tick();
    check("a_dec_q", 32'(q_a), 32'd1);

    // Hold with BI=0
    bi_a = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("a_hold_q", 32'(q_a), 32'd1);
      check("a_hold_bo", 32'(bo_a), 32'd0);
      check("a_hold_zero", 32'(zero_a), 32'd0);
    end

    // Terminal count: reload from D=1 or wrap to 3
    ld_a = 1'b1; d_a = 2'd1;
    tick();
    check("a_rl_ld", 32'(q_a), 32'd1);
    ld_a = 1'b0; bi_a = 1'b1;
    tick();
    check("a_rl_0", 32'(q_a), 32'd0);
`ifdef CBD_AUTORELOAD_EN
    tick(); check("a_rl_1", 32'(q_a), 32'd1);
    tick(); check("a_rl_2", 32'(q_a), 32'd0);
    tick(); check("a_rl_3", 32'(q_a), 32'd1);
    tick(); check("a_rl_4", 32'(q_a), 32'd0);
`else
    tick(); check("a_rl_1", 32'(q_a), 32'd3);
    tick(); check("a_rl_2", 32'(q_a), 32'd2);
    tick(); check("a_rl_3", 32'(q_a), 32'd1);
    tick(); check("a_rl_4", 32'(q_a), 32'd0);
`endif
    // Clear pulse restores reload value to all-ones
    #2 cd_a = 1'b0;
    #2 cd_a = 1'b1;
    check("a_pulse_q", 32'(q_a), 32'd0);
    tick();
    check("a_after_pulse_wrap", 32'(q_a), 32'd3);
    tick();
    check("a_after_pulse_dec", 32'(q_a), 32'd2);

    // Cascade: load both with 0, then count as one 4-bit counter
    ld_c = 1'b1; d0 = 2'd0; d1 = 2'd0; bi_c = 1'b1;
    #1;
    check("c_ld_bo0_masked", 32'(bo0), 32'd0);
    tick();
    ld_c = 1'b0;
    #1;
    check("c_q_zero", 32'({q1, q0}), 32'd0);
    check("c_bo1_zero", 32'(bo1), 32'd1);
    exp_c = 4'd0;
    for (int i = 0; i < 6; i++) begin
      tick();
`ifndef CBD_AUTORELOAD_EN
      exp_c = exp_c - 4'd1;
`endif
      check("c_q", 32'({q1, q0}), 32'(exp_c));
      check("c_bo1", 32'(bo1), (exp_c == 4'd0) ? 32'd1 : 32'd0);
    end

    // WIDTH=3, INIT=2: clear wins over load, count from INIT
    check("k_clr_q", 32'(q_k), 32'd2);
    check("k_clr_zero", 32'(zero_k), 32'd0);
    bi_k = 1'b1; ld_k = 1'b1; d_k = 3'd5;
    tick();
    check("k_clr_wins", 32'(q_k), 32'd2);
    ld_k = 1'b0;
    cd_k = 1'b1;
    tick(); check("k_cnt_1", 32'(q_k), 32'd1);
    tick(); check("k_cnt_0", 32'(q_k), 32'd0);
    check("k_bo_at_0", 32'(bo_k), 32'd1);
    tick(); check("k_cnt_wrap", 32'(q_k), 32'd7);
    tick(); check("k_cnt_6", 32'(q_k), 32'd6);
    #3 cd_k = 1'b0;
    #1;
    check("k_midclr_q", 32'(q_k), 32'd2);
    cd_k = 1'b1;
    tick();
    check("k_after_clr", 32'(q_k), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

endmodule
